pe_db: RTL and testbench
========================

PE_DB -- requirements
Module: pe_db

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of all data ports, signed two's complement.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits of the fixed-point format; legal range 0..DATA_WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pe_valid_in  input  1  compute qualifier for input_in/psum_in.
REQ-006 SHALL have port input_in  input  DATA_WIDTH  activation operand.
REQ-007 SHALL have port psum_in  input  DATA_WIDTH  upstream partial sum.
REQ-008 SHALL have port weight_in  input  DATA_WIDTH  weight into the shadow register.
REQ-009 SHALL have port weight_load  input  1  write weight_in into the shadow weight.
REQ-010 SHALL have port weight_swap  input  1  copy shadow weight into the active weight.
REQ-011 SHALL have port mode  input  1  0 = weight-stationary (add psum_in); 1 = output-stationary (local accumulator).
REQ-012 SHALL have port acc_clear  input  1  zero the local accumulator.
REQ-013 SHALL have port ovf_clear  input  1  clear the sticky overflow flag.
REQ-014 SHALL have port pe_valid_out  output  1  registered pe_valid_in.
REQ-015 SHALL have port input_out  output  DATA_WIDTH  registered input_in, forwarded to the neighbour.
REQ-016 SHALL have port psum_out  output  DATA_WIDTH  registered result.
REQ-017 SHALL have port weight_out  output  DATA_WIDTH  current shadow weight, for daisy-chained weight shifting.
REQ-018 SHALL have port ovf_sticky  output  1  any saturation since the last clear.

Function
REQ-019 Product SHALL be the full 2*DATA_WIDTH signed input_in*active_weight, arithmetically shifted right by FRAC_BITS (floor), then saturated to the DATA_WIDTH signed range.
REQ-020 Sum SHALL be the saturated product plus the addend, computed at DATA_WIDTH+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1]; addend = psum_in in mode 0, accumulator in mode 1.
REQ-021 Latency SHALL be 1 cycle: on a cycle with pe_valid_in=1, the next edge SHALL load input_out<=input_in and psum_out<=sum; in mode 1 it SHALL also load the accumulator<=sum.
REQ-022 On a cycle with pe_valid_in=0, input_out, psum_out and the accumulator SHALL hold.
REQ-023 pe_valid_out SHALL equal pe_valid_in delayed one cycle, every cycle, with no dependence on weight_load or weight_swap.
REQ-024 weight_load=1 SHALL set shadow<=weight_in and SHALL NOT block compute in the same cycle.
REQ-025 weight_swap=1 SHALL set active<=shadow; a compute in the same cycle SHALL use the pre-swap active weight.
REQ-026 weight_load and weight_swap in the same cycle: active SHALL receive the old shadow value and shadow SHALL receive weight_in.
REQ-027 acc_clear=1 with pe_valid_in=0 SHALL zero the accumulator; with pe_valid_in=1 in mode 1, the accumulator and psum_out SHALL receive the saturated product (addend treated as 0).
REQ-028 mode SHALL be sampled every cycle; the accumulator SHALL be untouched by mode-0 operations.
REQ-029 ovf_sticky SHALL set on any valid cycle where the product or the sum saturates; ovf_clear SHALL clear it; if set and clear coincide, set SHALL win.
REQ-030 weight_out SHALL be the shadow register output, with no extra delay.

Reset
REQ-031 rst=1 SHALL immediately zero pe_valid_out, input_out, psum_out, weight_out, the active weight, the accumulator and ovf_sticky, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight result; the first valid cycle after release SHALL compute with a zero weight.

Verification (DATA_WIDTH=16, FRAC_BITS=8)
REQ-033 Load 0x0200, swap, then valid with input 0x0180 and psum 0x0100 in mode 0 -> next cycle psum_out=0x0400, input_out=0x0180, pe_valid_out=1.
REQ-034 Active weight 0x0200, input 0x7F00, valid -> psum_out=0x7FFF and ovf_sticky=1; weight 0x0200 with input 0xFE80 and psum 0 -> psum_out=0xFD00.
REQ-035 Floor rounding: weight 0x0080 with input 0x0001 -> 0x0000; with input 0xFFFF -> 0xFFFF.
REQ-036 Mode 1, weight 0x0100, three valid cycles with input 0x0100 -> psum_out 0x0100, 0x0200, 0x0300; acc_clear together with a valid input of 0x0100 -> 0x0100.
REQ-037 Weight 0x0100 active, shadow 0x0300; swap and valid (input 0x0100) in the same cycle -> result 0x0100; next valid -> 0x0300; load and swap together -> active=old shadow, weight_out=new weight_in.
REQ-038 Assert rst asynchronously between edges during a streaming run -> all outputs are 0 before the next edge; ovf_sticky=0.

Source files
------------

// File: rtl/pe_db_if.sv
// Processing-element bus: compute operands, weight shifting and status.
// master drives operands/controls, slave is the PE.
interface pe_db_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  pe_valid_in;
    logic [DATA_WIDTH-1:0] input_in;
    logic [DATA_WIDTH-1:0] psum_in;
    logic [DATA_WIDTH-1:0] weight_in;
    logic                  weight_load;
    logic                  weight_swap;
    logic                  mode;
    logic                  acc_clear;
    logic                  ovf_clear;
    logic                  pe_valid_out;
    logic [DATA_WIDTH-1:0] input_out;
    logic [DATA_WIDTH-1:0] psum_out;
    logic [DATA_WIDTH-1:0] weight_out;
    logic                  ovf_sticky;

    modport master (
        output pe_valid_in, input_in, psum_in, weight_in,
        output weight_load, weight_swap, mode, acc_clear, ovf_clear,
        input  pe_valid_out, input_out, psum_out, weight_out, ovf_sticky
    );

    modport slave (
        input  pe_valid_in, input_in, psum_in, weight_in,
        input  weight_load, weight_swap, mode, acc_clear, ovf_clear,
        output pe_valid_out, input_out, psum_out, weight_out, ovf_sticky
    );
endinterface

// File: rtl/pe_db.sv
// Fixed-point systolic PE with double-buffered weight, saturating MAC
// and weight-/output-stationary modes.
module pe_db #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input logic   clk,
    input logic   rst,
    pe_db_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] shadow;
    logic [DW-1:0] active;
    logic [DW-1:0] acc;
    logic [DW-1:0] psum_q;
    logic [DW-1:0] input_q;
    logic          valid_q;
    logic          ovf_q;

    logic signed [2*DW-1:0] prod_full;
    logic signed [2*DW-1:0] prod_shift;
    logic [DW:0]            prod_hi;
    logic                   prod_ovf;
    logic [DW-1:0]          prod_sat;
    logic [DW-1:0]          addend;
    logic [DW:0]            sum_wide;
    logic                   sum_ovf;
    logic [DW-1:0]          sum_sat;

    assign prod_full  = $signed(bus.input_in) * $signed(active);
    assign prod_shift = prod_full >>> FRAC_BITS;

    // Fits in DW bits only if the bits above the sign all match it
    assign prod_hi  = prod_shift[2*DW-1:DW-1];
    assign prod_ovf = ~((&prod_hi) | ~(|prod_hi));
    assign prod_sat = prod_ovf ? (prod_shift[2*DW-1] ? S_MIN : S_MAX)
                               : prod_shift[DW-1:0];

    always_comb begin
        addend = bus.psum_in;
        if (bus.mode)
            addend = bus.acc_clear ? '0 : acc;
    end

    assign sum_wide = {prod_sat[DW-1], prod_sat} + {addend[DW-1], addend};
    assign sum_ovf  = sum_wide[DW] ^ sum_wide[DW-1];
    assign sum_sat  = sum_ovf ? (sum_wide[DW] ? S_MIN : S_MAX)
                              : sum_wide[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            acc     <= '0;
            psum_q  <= '0;
            input_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= bus.pe_valid_in;
            if (bus.weight_load)
                shadow <= bus.weight_in;
            if (bus.weight_swap)
                active <= shadow;
            if (bus.pe_valid_in) begin
                input_q <= bus.input_in;
                psum_q  <= sum_sat;
                if (bus.mode)
                    acc <= sum_sat;
            end else if (bus.acc_clear) begin
                acc <= '0;
            end
            // A new saturation outranks a simultaneous clear
            if (bus.pe_valid_in && (prod_ovf || sum_ovf))
                ovf_q <= 1'b1;
            else if (bus.ovf_clear)
                ovf_q <= 1'b0;
        end
    end

    assign bus.pe_valid_out = valid_q;
    assign bus.input_out    = input_q;
    assign bus.psum_out     = psum_q;
    assign bus.weight_out   = shadow;
    assign bus.ovf_sticky   = ovf_q;
endmodule

// File: tb/tb_pe_db.sv
// Directed self-checking bench for pe_db (DATA_WIDTH=16, FRAC_BITS=8).
module tb_pe_db;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pe_db_if #(.DATA_WIDTH(16)) bus ();

    pe_db #(
        .DATA_WIDTH(16),
        .FRAC_BITS (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pe_valid_in = 1'b0;
        bus.weight_load = 1'b0;
        bus.weight_swap = 1'b0;
        bus.acc_clear   = 1'b0;
        bus.ovf_clear   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [15:0] w);
        idle();
        bus.weight_load = 1'b1;
        bus.weight_in   = w;
        tick();
        idle();
        bus.weight_swap = 1'b1;
        tick();
        idle();
    endtask

    task automatic comp(input logic [15:0] a, input logic [15:0] p);
        bus.pe_valid_in = 1'b1;
        bus.input_in    = a;
        bus.psum_in     = p;
        tick();
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.mode      = 1'b0;
        bus.input_in  = '0;
        bus.psum_in   = '0;
        bus.weight_in = '0;
        idle();
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.pe_valid_out}, 32'd0);
        chk("rst_input", {16'd0, bus.input_out}, 32'd0);
        chk("rst_psum", {16'd0, bus.psum_out}, 32'd0);
        chk("rst_wout", {16'd0, bus.weight_out}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf_sticky}, 32'd0);
        rst = 1'b0;
        tick();

        // weight-stationary basic MAC
        load_w(16'h0200);
        chk("wout_load", {16'd0, bus.weight_out}, 32'h0200);
        comp(16'h0180, 16'h0100);
        chk("ws_psum", {16'd0, bus.psum_out}, 32'h0400);
        chk("ws_input", {16'd0, bus.input_out}, 32'h0180);
        chk("ws_valid", {31'd0, bus.pe_valid_out}, 32'd1);

        comp(16'h7F00, 16'h0000);
        chk("sat_pos", {16'd0, bus.psum_out}, 32'h7FFF);
        chk("sat_ovf", {31'd0, bus.ovf_sticky}, 32'd1);
        bus.ovf_clear = 1'b1;
        tick();
        idle();
        chk("ovf_clr", {31'd0, bus.ovf_sticky}, 32'd0);
        chk("hold_psum", {16'd0, bus.psum_out}, 32'h7FFF);
        chk("valid_drop", {31'd0, bus.pe_valid_out}, 32'd0);
        comp(16'hFE80, 16'h0000);
        chk("neg_prod", {16'd0, bus.psum_out}, 32'hFD00);

        // floor rounding of the shifted product
        load_w(16'h0080);
        comp(16'h0001, 16'h0000);
        chk("floor_pos", {16'd0, bus.psum_out}, 32'h0000);
        comp(16'hFFFF, 16'h0000);
        chk("floor_neg", {16'd0, bus.psum_out}, 32'hFFFF);

        // output-stationary accumulate; psum_in must be ignored
        load_w(16'h0100);
        bus.acc_clear = 1'b1;
        tick();
        idle();
        bus.mode = 1'b1;
        comp(16'h0100, 16'h1234);
        chk("os_acc1", {16'd0, bus.psum_out}, 32'h0100);
        comp(16'h0100, 16'h1234);
        chk("os_acc2", {16'd0, bus.psum_out}, 32'h0200);
        comp(16'h0100, 16'h1234);
        chk("os_acc3", {16'd0, bus.psum_out}, 32'h0300);
        bus.acc_clear = 1'b1;
        comp(16'h0100, 16'h1234);
        chk("os_clr_valid", {16'd0, bus.psum_out}, 32'h0100);
        comp(16'h0100, 16'h1234);
        chk("os_after_clr", {16'd0, bus.psum_out}, 32'h0200);
        bus.mode = 1'b0;

        // swap/compute ordering
        bus.weight_load = 1'b1;
        bus.weight_in   = 16'h0300;
        tick();
        idle();
        bus.weight_swap = 1'b1;
        comp(16'h0100, 16'h0000);
        chk("swap_same", {16'd0, bus.psum_out}, 32'h0100);
        comp(16'h0100, 16'h0000);
        chk("swap_next", {16'd0, bus.psum_out}, 32'h0300);
        bus.weight_load = 1'b1;
        bus.weight_swap = 1'b1;
        bus.weight_in   = 16'h0500;
        tick();
        idle();
        chk("ldsw_wout", {16'd0, bus.weight_out}, 32'h0500);
        comp(16'h0100, 16'h0000);
        chk("ldsw_active", {16'd0, bus.psum_out}, 32'h0300);

        // mode-0 work leaves the accumulator (0x0200) intact
        bus.mode = 1'b1;
        comp(16'h0000, 16'h0000);
        chk("acc_kept", {16'd0, bus.psum_out}, 32'h0200);
        bus.mode = 1'b0;

        // sum saturation and set-wins-over-clear
        comp(16'h0100, 16'h7F00);
        chk("sum_sat_pos", {16'd0, bus.psum_out}, 32'h7FFF);
        chk("sum_ovf", {31'd0, bus.ovf_sticky}, 32'd1);
        bus.ovf_clear = 1'b1;
        comp(16'hFF00, 16'h8000);
        chk("sum_sat_neg", {16'd0, bus.psum_out}, 32'h8000);
        chk("set_wins", {31'd0, bus.ovf_sticky}, 32'd1);

        // asynchronous reset mid-stream
        bus.pe_valid_in = 1'b1;
        bus.input_in    = 16'h0100;
        bus.psum_in     = 16'h0042;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.pe_valid_out}, 32'd0);
        chk("arst_input", {16'd0, bus.input_out}, 32'd0);
        chk("arst_psum", {16'd0, bus.psum_out}, 32'd0);
        chk("arst_wout", {16'd0, bus.weight_out}, 32'd0);
        chk("arst_ovf", {31'd0, bus.ovf_sticky}, 32'd0);
        #1 rst = 1'b0;
        tick();
        idle();
        chk("post_rst_zero_w", {16'd0, bus.psum_out}, 32'h0042);
        chk("post_rst_valid", {31'd0, bus.pe_valid_out}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
